triangle_scan: RTL and testbench

//   Raster-scan sequencer directly upstream of the triangle point-in-triangle test.

---
 rtl/triangle_scan.sv | 221 ++++++++++++++++++++++
 tb/tb_triangle_scan.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_scan.sv
// triangle_scan: latches a triangle, scans its screen-clamped bounding box in raster order.
// Latency: start at cycle 0 -> SETUP cycle 1 -> SCAN cycle 2 -> first pix_valid at cycle 3.
// Backpressure: pix_ready low freezes the raster point and the output beat; nothing is dropped.
// Optional feature: define TRI_SCAN_COUNT_EN to enable the inside-pixel counter on pix_count.

module triangle_scan #(
    parameter int SCR_W = 640,
    parameter int SCR_H = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] x1,
    input  logic [10:0] y1,
    input  logic [10:0] x2,
    input  logic [10:0] y2,
    input  logic [10:0] x3,
    input  logic [10:0] y3,
    output logic        busy,
    output logic        done,
    output logic [10:0] tx1,
    output logic [10:0] ty1,
    output logic [10:0] tx2,
    output logic [10:0] ty2,
    output logic [10:0] tx3,
    output logic [10:0] ty3,
    output logic [10:0] px,
    output logic [10:0] py,
    input  logic        inside_in,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_inside,
    output logic [22:0] pix_count
);

    localparam logic [10:0] X_LIM = 11'(SCR_W - 1);
    localparam logic [10:0] Y_LIM = 11'(SCR_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [10:0] ymin;
    logic [10:0] ymax;

    logic [10:0] vx_min;
    logic [10:0] vx_max;
    logic [10:0] vy_min;
    logic [10:0] vy_max;
    logic [10:0] x_hi;
    logic [10:0] y_hi;
    logic        box_empty;

    logic        advance;
    logic        last_col;
    logic        last_row;
    logic        start_acc;

    function automatic logic [10:0] min3(input logic [10:0] a, input logic [10:0] b,
                                         input logic [10:0] c);
        logic [10:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [10:0] max3(input logic [10:0] a, input logic [10:0] b,
                                         input logic [10:0] c);
        logic [10:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bounding box of the latched vertices, max edges clamped to the screen.
    always_comb begin
        vx_min    = min3(tx1, tx2, tx3);
        vx_max    = max3(tx1, tx2, tx3);
        vy_min    = min3(ty1, ty2, ty3);
        vy_max    = max3(ty1, ty2, ty3);
        x_hi      = (vx_max > X_LIM) ? X_LIM : vx_max;
        y_hi      = (vy_max > Y_LIM) ? Y_LIM : vy_max;
        box_empty = (vx_min > X_LIM) || (vy_min > Y_LIM);
    end

    // Handshake and raster position decodes shared by the FSM and datapath.
    always_comb begin
        advance   = !pix_valid || pix_ready;
        last_col  = (px == xmax);
        last_row  = (py == ymax);
        start_acc = (state == IDLE) && start;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: an empty box goes straight to DRAIN with nothing emitted.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SETUP;
            SETUP:   next_state = box_empty ? DRAIN : SCAN;
            SCAN:    if (advance && last_col && last_row) next_state = DRAIN;
            DRAIN:   if (advance) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs: busy covers SETUP through DRAIN, so it drops with done.
    always_comb begin
        busy = (state != IDLE);
    end

    // Vertex latch; start outside IDLE leaves the latched triangle alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx1 <= '0;
            ty1 <= '0;
            tx2 <= '0;
            ty2 <= '0;
            tx3 <= '0;
            ty3 <= '0;
        end else if (start_acc) begin
            tx1 <= x1;
            ty1 <= y1;
            tx2 <= x2;
            ty2 <= y2;
            tx3 <= x3;
            ty3 <= y3;
        end
    end

    // Box registers are loaded once in SETUP and stay put for the rest of the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            xmin <= '0;
            xmax <= '0;
            ymin <= '0;
            ymax <= '0;
        end else if (state == SETUP) begin
            xmin <= vx_min;
            xmax <= x_hi;
            ymin <= vy_min;
            ymax <= y_hi;
        end
    end

    // Raster stepper: x runs to xmax then wraps with y+1; holds on the last point.
    always_ff @(posedge clk) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (state == SETUP) begin
            px <= vx_min;
            py <= vy_min;
        end else if (state == SCAN && advance) begin
            if (!last_col) begin
                px <= px + 11'd1;
            end else if (!last_row) begin
                px <= xmin;
                py <= py + 11'd1;
            end
        end
    end

    // Output beat register: loads the current point whenever the slot is free.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_inside <= 1'b0;
        end else if (state == SCAN && advance) begin
            pix_valid  <= 1'b1;
            pix_x      <= px;
            pix_y      <= py;
            pix_inside <= inside_in;
        end else if (state == DRAIN && advance) begin
            pix_valid  <= 1'b0;
        end
    end

    // Done pulses in the cycle after the last beat leaves (or after an empty box).
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) && advance;
        end
    end

`ifdef TRI_SCAN_COUNT_EN
    // Inside-pixel counter: cleared by an accepted start, held after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_count <= '0;
        end else if (start_acc) begin
            pix_count <= '0;
        end else if (pix_valid && pix_ready && pix_inside) begin
            pix_count <= pix_count + 23'd1;
        end
    end
`else
    assign pix_count = '0;
`endif

endmodule

// File: tb/tb_triangle_scan.sv
// Bench for triangle_scan: table of triangles plus random ones, checked against a raster model.
// The bench models the downstream point-in-triangle unit combinationally from px/py.
// pix_ready is driven steady, toggling, or random to exercise backpressure.

module tb_triangle_scan;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] x1, y1, x2, y2, x3, y3;
    logic        busy, done;
    logic [10:0] tx1, ty1, tx2, ty2, tx3, ty3;
    logic [10:0] px, py;
    logic        inside_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [10:0] pix_x, pix_y;
    logic        pix_inside;
    logic [22:0] pix_count;

    always #5 clk = ~clk;

    triangle_scan #(.SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .busy(busy), .done(done),
        .tx1(tx1), .ty1(ty1), .tx2(tx2), .ty2(ty2), .tx3(tx3), .ty3(ty3),
        .px(px), .py(py), .inside_in(inside_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_inside(pix_inside),
        .pix_count(pix_count)
    );

    typedef struct {
        int x1, y1, x2, y2, x3, y3;
        int mode;        // 0 ready high, 1 ready toggling, 2 ready random
        int exp_beats;   // -1: model only
        int abort_at;    // >0: assert reset right after this many accepted beats
        int restart_mid; // pulse start with other vertices during SCAN
        int tag;         // 1: T1 spot checks, 2: T2 spot checks
    } vec_t;

    typedef struct {
        int x;
        int y;
        bit ins;
    } beat_t;

    beat_t exp_q[$];
    int    vx1, vy1, vx2, vy2, vx3, vy3;
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit tri_has(input int x, input int y, input int ax, input int ay,
                                   input int bx, input int by, input int cx, input int cy);
        longint e0, e1, e2;
        e0 = longint'(bx - ax) * (y - ay) - longint'(by - ay) * (x - ax);
        e1 = longint'(cx - bx) * (y - by) - longint'(cy - by) * (x - bx);
        e2 = longint'(ax - cx) * (y - cy) - longint'(ay - cy) * (x - cx);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    // Downstream point-in-triangle unit for the triangle currently under test.
    always_comb inside_in = tri_has(int'(px), int'(py), vx1, vy1, vx2, vy2, vx3, vy3);

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Expected beat list: every pixel of the clamped box, row-major.
    task automatic build_model(output int n_in);
        int xl, xh, yl, yh;
        beat_t b;
        exp_q.delete();
        n_in = 0;
        xl = imin(imin(vx1, vx2), vx3);
        yl = imin(imin(vy1, vy2), vy3);
        xh = imin(imax(imax(vx1, vx2), vx3), SCR_W - 1);
        yh = imin(imax(imax(vy1, vy2), vy3), SCR_H - 1);
        if (xl <= SCR_W - 1 && yl <= SCR_H - 1) begin
            for (int y = yl; y <= yh; y++) begin
                for (int x = xl; x <= xh; x++) begin
                    b.x   = x;
                    b.y   = y;
                    b.ins = tri_has(x, y, vx1, vy1, vx2, vy2, vx3, vy3);
                    exp_q.push_back(b);
                    n_in += int'(b.ins);
                end
            end
        end
    endtask

    task automatic run_vec(input vec_t t);
        beat_t       b;
        int          n_in, n_exp, cyc, beats, last_acc, budget, exp_cnt;
        bit          pv, pr, pin, got_done, aborted, pulsed, seen33;
        logic [10:0] ppx, ppy;

        vx1 = t.x1; vy1 = t.y1; vx2 = t.x2; vy2 = t.y2; vx3 = t.x3; vy3 = t.y3;
        build_model(n_in);
        n_exp = exp_q.size();
        if (t.exp_beats >= 0) chk("model_beat_count", n_exp, t.exp_beats);

        @(negedge clk);
        start = 1'b1;
        x1 = 11'(t.x1); y1 = 11'(t.y1); x2 = 11'(t.x2);
        y2 = 11'(t.y2); x3 = 11'(t.x3); y3 = 11'(t.y3);
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x1 = 11'($urandom); y1 = 11'($urandom); x2 = 11'($urandom);
        y2 = 11'($urandom); x3 = 11'($urandom); y3 = 11'($urandom);
        cyc = 1;
        chk("busy_in_setup", busy, 1);
        chk("latched_v_a", {tx1, ty1, tx2}, {11'(t.x1), 11'(t.y1), 11'(t.x2)});
        chk("latched_v_b", {ty2, tx3, ty3}, {11'(t.y2), 11'(t.x3), 11'(t.y3)});
        chk("count_clear", pix_count, 0);

        pv = 0; pr = 0; pin = 0; ppx = '0; ppy = '0;
        beats = 0; last_acc = -1; got_done = 0; aborted = 0; pulsed = 0; seen33 = 0;
        exp_cnt = 0;
        budget = 6 * n_exp + 60;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (t.mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 2 == 1);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (t.restart_mid != 0 && beats >= 5 && !pulsed) begin
                start = 1'b1; pulsed = 1;
                x1 = 11'd100; y1 = 11'd100; x2 = 11'd103; y2 = 11'd100; x3 = 11'd100; y3 = 11'd103;
            end else begin
                start = 1'b0;
            end
            if (pv && !pr) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_xy", {pix_x, pix_y}, {ppx, ppy});
                chk("stall_inside", pix_inside, pin);
            end
            if (cyc == 2) chk("valid_low_cyc2", pix_valid, 0);
            if (cyc == 3 && n_exp > 0) chk("first_valid_cyc3", pix_valid, 1);
            if (done) begin
                got_done = 1;
                break;
            end
            if (pix_valid && pix_ready) begin
                if (pix_inside) exp_cnt++;
                if (pix_x == 11'd3 && pix_y == 11'd3) seen33 = 1;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", beats + 1, n_exp);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_xy", {pix_x, pix_y}, {11'(b.x), 11'(b.y)});
                    chk("beat_inside", pix_inside, b.ins);
                    if (t.tag == 1 && b.x == 3 && b.y == 3) chk("t1_inside_3_3", pix_inside, 1);
                    if (t.tag == 1 && b.x == 9 && b.y == 9) chk("t1_inside_9_9", pix_inside, 0);
                end
                beats++;
                last_acc = cyc;
                if (t.abort_at > 0 && beats == t.abort_at) begin
                    reset = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    chk("abort_busy", busy, 0);
                    chk("abort_valid", pix_valid, 0);
                    chk("abort_count", pix_count, 0);
                    chk("abort_done", done, 0);
                    chk("abort_pix_xy", {pix_x, pix_y}, 0);
                    reset = 1'b0;
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                    aborted = 1;
                    break;
                end
            end
            pv = pix_valid; pr = pix_ready; ppx = pix_x; ppy = pix_y; pin = pix_inside;
        end

        if (!aborted) begin
            chk("done_seen", got_done, 1);
            chk("beat_total", beats, n_exp);
            if (n_exp > 0) chk("done_after_last", cyc, last_acc + 1);
            else           chk("done_empty_cycle", cyc, 3);
            chk("done_valid_low", pix_valid, 0);
            chk("done_busy_low", busy, 0);
`ifdef TRI_SCAN_COUNT_EN
            chk("inside_count_model", exp_cnt, n_in);
            chk("pix_count", pix_count, n_in);
`else
            chk("pix_count_tied", pix_count, 0);
`endif
            chk("held_v_a", {tx1, ty1, tx2}, {11'(t.x1), 11'(t.y1), 11'(t.x2)});
            chk("held_v_b", {ty2, tx3, ty3}, {11'(t.y2), 11'(t.x3), 11'(t.y3)});
            if (t.tag == 2) chk("t2_no_3_3", seen33, 0);
            @(negedge clk);
            start = 1'b0;
            chk("done_one_cycle", done, 0);
`ifdef TRI_SCAN_COUNT_EN
            chk("pix_count_hold", pix_count, n_in);
`endif
        end
    endtask

    initial begin
        vec_t tab[10];
        vec_t rv;
        int   bx, by;

        //          x1   y1   x2   y2   x3   y3  mode beats abort mid tag
        tab[0] = '{  0,   0,  10,   0,   0,  10,  0,  121,  0,  0,  1};
        tab[1] = '{ 15,  15,  30,   0,  15,   0,  0,  256,  0,  0,  2};
        tab[2] = '{  0,   0,  10,   0,   0,  10,  1,  121,  0,  0,  1};
        tab[3] = '{700,   5, 800,   5, 750,  20,  0,    0,  0,  0,  0};
        tab[4] = '{600,   0, 700,   0, 600,   2,  0,  120,  0,  0,  0};
        tab[5] = '{  0,   0,  10,   0,   0,  10,  0,  121, 40,  0,  1};
        tab[6] = '{  0,   0,  10,   0,   0,  10,  0,  121,  0,  0,  1};
        tab[7] = '{ 15,  15,  30,   0,  15,   0,  2,  256,  0,  1,  2};
        tab[8] = '{ 50,  60,  50,  60,  50,  60,  2,    1,  0,  0,  0};
        tab[9] = '{  5, 470,   5, 500,   8, 490,  2,   40,  0,  0,  0};

        reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
        vx1 = 0; vy1 = 0; vx2 = 0; vy2 = 0; vx3 = 0; vy3 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_inside", pix_inside, 0);
        chk("rst_pxy", {px, py}, 0);
        chk("rst_pix_xy", {pix_x, pix_y}, 0);
        chk("rst_tv", {tx1, ty1, tx2, ty2, tx3}, 0);
        chk("rst_count", pix_count, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(tab[i]);

        for (int i = 0; i < 6; i++) begin
            bx = int'($urandom_range(0, 660));
            by = int'($urandom_range(0, 495));
            rv.x1 = bx + int'($urandom_range(0, 15)); rv.y1 = by + int'($urandom_range(0, 15));
            rv.x2 = bx + int'($urandom_range(0, 15)); rv.y2 = by + int'($urandom_range(0, 15));
            rv.x3 = bx + int'($urandom_range(0, 15)); rv.y3 = by + int'($urandom_range(0, 15));
            rv.mode = 2; rv.exp_beats = -1; rv.abort_at = 0; rv.restart_mid = 0; rv.tag = 0;
            run_vec(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
